// File: rtl/dnn_pkg.sv
// Shared types and block geometry for the DNN memory arbiter.
// A block is BLK_WORDS words of WORD_BYTES bytes, fetched in one read.
package dnn_pkg;

    localparam int BLK_BYTES  = 64;
    localparam int BLK_WORDS  = 8;
    localparam int WORD_BYTES = BLK_BYTES / BLK_WORDS;

    localparam logic [31:0] BLK_STRIDE = 32'(BLK_BYTES);

    typedef logic [BLK_WORDS*WORD_BYTES-1:0][7:0] blk_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/dnn_rr_arb2.sv
// Two-way round-robin pick between the weight (bit 0) and image (bit 1) loaders.
// last_grant = 1 means the image loader won the previous contest.
module dnn_rr_arb2 (
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (pend)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dnn_mem_arbiter.sv
// Shares one block-read memory port between the weight and image loaders,
// one outstanding read at a time, with per-loader advancing block addresses.
module dnn_mem_arbiter
    import dnn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [31:0]               wt_base_addr,
    input  logic [31:0]               img_base_addr,
    input  logic                      wt_req,
    input  logic                      img_req,
    output logic                      wt_ready,
    output logic                      img_ready,
    output logic [BLK_BYTES-1:0][7:0] mem_data,
    output logic                      rd_valid,
    output logic [31:0]               rd_addr,
    input  logic                      rd_accept,
    input  logic                      rd_data_valid,
    input  logic [BLK_BYTES-1:0][7:0] rd_data,
    output logic                      busy,
    output logic                      req_err
);

    state_e                      state_q;
    logic [1:0]                  pend_q;
    logic [1:0]                  pend_d;
    logic [1:0]                  winner_q;
    logic                        last_grant_q;
    logic [31:0]                 wt_cnt_q;
    logic [31:0]                 img_cnt_q;
    logic [31:0]                 rd_addr_q;
    logic                        rd_valid_q;
    logic                        wt_ready_q;
    logic                        img_ready_q;
    logic [BLK_BYTES-1:0][7:0]   mem_data_q;
    logic                        req_err_q;

    logic [1:0] req_v;
    logic [1:0] clr;
    logic [1:0] dup;
    logic [1:0] grant;

    dnn_rr_arb2 u_arb (
        .pend       (pend_q),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // A request landing in its own RESP cycle re-arms the pend rather than erroring.
    always_comb begin
        req_v  = {img_req, wt_req};
        clr    = (state_q == ST_RESP) ? winner_q : 2'b00;
        pend_d = (pend_q & ~clr) | req_v;
        dup    = req_v & pend_q & ~clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= 2'b00;
            winner_q     <= 2'b00;
            last_grant_q <= 1'b1;
            wt_cnt_q     <= '0;
            img_cnt_q    <= '0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            wt_ready_q   <= 1'b0;
            img_ready_q  <= 1'b0;
            mem_data_q   <= '0;
            req_err_q    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            wt_ready_q  <= 1'b0;
            img_ready_q <= 1'b0;
            if (|dup) begin
                req_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|pend_q) begin
                        winner_q   <= grant;
                        // Rotation only moves on contested grants, so a lone
                        // request does not steal the next tie from the other side.
                        if (pend_q == 2'b11) begin
                            last_grant_q <= grant[1];
                        end
                        rd_addr_q  <= grant[0] ? wt_cnt_q : img_cnt_q;
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else if (start) begin
                        wt_cnt_q  <= wt_base_addr;
                        img_cnt_q <= img_base_addr;
                    end
                end
                ST_ISSUE: begin
                    if (rd_accept) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_data_valid) begin
                        mem_data_q  <= rd_data;
                        wt_ready_q  <= winner_q[0];
                        img_ready_q <= winner_q[1];
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (winner_q[0]) begin
                        wt_cnt_q <= wt_cnt_q + BLK_STRIDE;
                    end
                    if (winner_q[1]) begin
                        img_cnt_q <= img_cnt_q + BLK_STRIDE;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wt_ready  = wt_ready_q;
    assign img_ready = img_ready_q;
    assign mem_data  = mem_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_addr   = rd_addr_q;
    assign req_err   = req_err_q;
    assign busy      = (state_q != ST_IDLE) || (|pend_q);

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// Directed bench for dnn_mem_arbiter: reset, latency, round-robin order,
// backpressure, address wrap, duplicate-request error and mid-read reset.
module tb_dnn_mem_arbiter;
    import dnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] wt_base_addr = '0;
    logic [31:0] img_base_addr = '0;
    logic        wt_req = 1'b0;
    logic        img_req = 1'b0;
    logic        wt_ready;
    logic        img_ready;
    blk_t        mem_data;
    logic        rd_valid;
    logic [31:0] rd_addr;
    logic        rd_accept = 1'b0;
    logic        rd_data_valid = 1'b0;
    blk_t        rd_data = '0;
    logic        busy;
    logic        req_err;

    int total = 0;
    int bad = 0;

    dnn_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .wt_base_addr  (wt_base_addr),
        .img_base_addr (img_base_addr),
        .wt_req        (wt_req),
        .img_req       (img_req),
        .wt_ready      (wt_ready),
        .img_ready     (img_ready),
        .mem_data      (mem_data),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_accept     (rd_accept),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .req_err       (req_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic blk_t make_blk(input logic [7:0] seed);
        blk_t b;
        for (int k = 0; k < BLK_BYTES; k++) begin
            b[k] = seed + 8'(k);
        end
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] wb, input logic [31:0] ib);
        wt_base_addr  = wb;
        img_base_addr = ib;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_req(input logic w, input logic i);
        wt_req  = w;
        img_req = i;
        step();
        wt_req  = 1'b0;
        img_req = 1'b0;
    endtask

    // Plays the memory: waits for rd_valid, holds rd_accept low acc_delay
    // extra cycles, accepts, returns data next cycle. Ends in the RESP cycle.
    task automatic serve(input int acc_delay, input blk_t data,
                         output logic [31:0] addr_seen, output logic [1:0] rdy_seen,
                         output int wait_cyc, output logic clean, output logic to);
        to = 1'b0;
        clean = 1'b1;
        wait_cyc = 0;
        addr_seen = '0;
        rdy_seen = '0;
        while (rd_valid !== 1'b1 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        if (rd_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        addr_seen = rd_addr;
        for (int k = 0; k < acc_delay; k++) begin
            step();
            if (rd_valid !== 1'b1 || rd_addr !== addr_seen) clean = 1'b0;
        end
        rd_accept = 1'b1;
        step();
        rd_accept = 1'b0;
        if (rd_valid !== 1'b0) clean = 1'b0;
        rd_data = data;
        rd_data_valid = 1'b1;
        step();
        rd_data_valid = 1'b0;
        rdy_seen = {img_ready, wt_ready};
    endtask

    task automatic test_reset();
        wt_req = 1'b1;
        img_req = 1'b1;
        do_reset();
        wt_req = 1'b0;
        img_req = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if ({img_ready, wt_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {img_ready, wt_ready}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (req_err !== 1'b0) begin bad++; $display("FAIL reset_req_err got=%b want=0", req_err); end
        total++; if (rd_addr !== 32'h0) begin bad++; $display("FAIL reset_rd_addr got=%h want=0", rd_addr); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_mem_data got=%h want=0", mem_data); end
    endtask

    task automatic test_single();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        blk_t        d0;
        d0 = make_blk(8'h11);
        do_start(32'h0000_1000, 32'h0000_8000);
        pulse_req(1'b1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_pend got=%b want=1", busy); end
        serve(0, d0, a, r, w, c, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=1 want=0"); end
        total++; if (a !== 32'h0000_1000) begin bad++; $display("FAIL single_addr got=%h want=00001000", a); end
        total++; if (w !== 1) begin bad++; $display("FAIL single_issue_lat got=%0d want=1", w); end
        total++; if (r !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", r); end
        total++; if (mem_data !== d0) begin bad++; $display("FAIL single_mem_data got=%h want=%h", mem_data, d0); end
        step();
        total++; if ({img_ready, wt_ready} !== 2'b00) begin bad++; $display("FAIL single_pulse_width got=%b want=00", {img_ready, wt_ready}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_done got=%b want=0", busy); end
        total++; if (mem_data !== d0) begin bad++; $display("FAIL single_mem_hold got=%h want=%h", mem_data, d0); end
        pulse_req(1'b1, 1'b0);
        serve(0, make_blk(8'h40), a, r, w, c, to);
        total++; if (a !== 32'h0000_1040) begin bad++; $display("FAIL single_next_addr got=%h want=00001040", a); end
        total++; if (r !== 2'b01) begin bad++; $display("FAIL single_next_ready got=%b want=01", r); end
        step();
    endtask

    task automatic test_round_robin();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        do_reset();
        do_start(32'h0000_1000, 32'h0000_8000);
        pulse_req(1'b1, 1'b1);
        serve(0, make_blk(8'h01), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_1000 || r !== 2'b01) begin bad++; $display("FAIL rr_first got addr=%h rdy=%b want addr=00001000 rdy=01", a, r); end
        step();
        serve(0, make_blk(8'h02), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_8000 || r !== 2'b10) begin bad++; $display("FAIL rr_second got addr=%h rdy=%b want addr=00008000 rdy=10", a, r); end
        step();
        pulse_req(1'b1, 1'b1);
        serve(0, make_blk(8'h03), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_8040 || r !== 2'b10) begin bad++; $display("FAIL rr_third got addr=%h rdy=%b want addr=00008040 rdy=10", a, r); end
        step();
        serve(0, make_blk(8'h04), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_1040 || r !== 2'b01) begin bad++; $display("FAIL rr_fourth got addr=%h rdy=%b want addr=00001040 rdy=01", a, r); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        int          extra;
        do_reset();
        do_start(32'h0000_2000, 32'h0000_A000);
        pulse_req(1'b1, 1'b0);
        // first observation plus 4 more: rd_accept low for 5 cycles of ISSUE
        serve(4, make_blk(8'h55), a, r, w, c, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
        total++; if (c !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", c); end
        total++; if (a !== 32'h0000_2000) begin bad++; $display("FAIL bp_addr got=%h want=00002000", a); end
        total++; if (r !== 2'b01) begin bad++; $display("FAIL bp_ready got=%b want=01", r); end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rd_valid === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL bp_extra_reads got=%0d want=0", extra); end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        do_reset();
        do_start(32'hFFFF_FFC0, 32'h0000_0000);
        pulse_req(1'b1, 1'b0);
        serve(0, make_blk(8'hA0), a, r, w, c, to);
        total++; if (to || a !== 32'hFFFF_FFC0) begin bad++; $display("FAIL wrap_first got=%h want=ffffffc0", a); end
        step();
        pulse_req(1'b1, 1'b0);
        serve(0, make_blk(8'hB0), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_0000) begin bad++; $display("FAIL wrap_second got=%h want=00000000", a); end
        step();
    endtask

    task automatic test_req_err();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        int          wt_pulses;
        do_reset();
        do_start(32'h0000_3000, 32'h0000_9000);
        pulse_req(1'b1, 1'b0);
        step();
        total++; if (rd_valid !== 1'b1 || rd_addr !== 32'h0000_3000) begin bad++; $display("FAIL err_issue got valid=%b addr=%h want valid=1 addr=00003000", rd_valid, rd_addr); end
        rd_accept = 1'b1;
        step();
        rd_accept = 1'b0;
        wt_req = 1'b1;
        img_req = 1'b1;
        rd_data = make_blk(8'hC0);
        rd_data_valid = 1'b1;
        step();
        wt_req = 1'b0;
        img_req = 1'b0;
        rd_data_valid = 1'b0;
        total++; if (wt_ready !== 1'b1) begin bad++; $display("FAIL err_wt_ready got=%b want=1", wt_ready); end
        total++; if (req_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", req_err); end
        step();
        serve(0, make_blk(8'hD0), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_9000 || r !== 2'b10) begin bad++; $display("FAIL err_img_served got addr=%h rdy=%b want addr=00009000 rdy=10", a, r); end
        wt_pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (wt_ready === 1'b1 || rd_valid === 1'b1) wt_pulses++;
        end
        total++; if (wt_pulses !== 0) begin bad++; $display("FAIL err_dropped got=%0d want=0", wt_pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_busy got=%b want=0", busy); end
        total++; if (req_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", req_err); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a;
        logic [1:0]  r;
        int          w;
        logic        c;
        logic        to;
        do_reset();
        do_start(32'h0000_5000, 32'h0000_0000);
        pulse_req(1'b1, 1'b0);
        wt_base_addr = 32'h0000_6000;
        start = 1'b1;
        step();
        start = 1'b0;
        serve(0, make_blk(8'h77), a, r, w, c, to);
        total++; if (to || a !== 32'h0000_5000) begin bad++; $display("FAIL start_ignored got=%h want=00005000", a); end
        step();
    endtask

    task automatic test_rst_mid();
        int rdy_cnt;
        do_reset();
        do_start(32'h0000_4000, 32'h0000_0000);
        pulse_req(1'b1, 1'b0);
        step();
        rd_accept = 1'b1;
        step();
        rd_accept = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_data = make_blk(8'hE0);
        rd_data_valid = 1'b1;
        step();
        rd_data_valid = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (wt_ready === 1'b1 || img_ready === 1'b1) rdy_cnt++;
            step();
        end
        total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL rstmid_ready got=%0d want=0", rdy_cnt); end
        total++; if (mem_data !== '0) begin bad++; $display("FAIL rstmid_mem_data got=%h want=0", mem_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rd_valid got=%b want=0", rd_valid); end
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_req_err();
        test_start_ignored();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dnn_mem_arbiter.md
DNN_MEM_ARBITER -- requirements
Module: dnn_mem_arbiter

Interface
REQ-001 SHALL use one clock and reset: clk is the single clock; rst is synchronous and active-high.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  load base addresses into address counters
- wt_base_addr  in  32  weight-block base byte address
- img_base_addr  in  32  image-block base byte address
- wt_req  in  1  single-cycle block request from weight loader
- img_req  in  1  single-cycle block request from image loader
- wt_ready  out  1  one-cycle pulse: block for weight loader on mem_data
- img_ready  out  1  one-cycle pulse: block for image loader on mem_data
- mem_data  out  64 x [7:0]  last captured 8-word block, shared by both requesters
- rd_valid  out  1  read request to memory
- rd_addr  out  32  block byte address of the read
- rd_accept  in  1  memory accepted the read
- rd_data_valid  in  1  read data present
- rd_data  in  64 x [7:0]  read data block
- busy  out  1  state != IDLE or any request pending
- req_err  out  1  sticky: a request arrived while that requester was already pending

Function
REQ-003 SHALL latch wt_req/img_req into pend_wt/pend_img; if set and clear occur on the same cycle, set wins.
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-005 In IDLE with any pend set, the FSM SHALL pick a winner, register rd_addr from the winner's counter, and go to ISSUE next cycle; a pend set in cycle N is issued no earlier than cycle N+1.
REQ-006 Winner rule SHALL be: a sole pender wins; when both pend, the one not granted last wins; after reset, the weight loader wins the first tie.
REQ-007 In ISSUE, rd_valid SHALL be 1 and rd_addr stable until rd_accept; rd_accept moves the FSM to WAIT.
REQ-008 In WAIT, rd_data_valid SHALL capture rd_data into mem_data and move the FSM to RESP; rd_data_valid outside WAIT is ignored.
REQ-009 In RESP, exactly one of wt_ready/img_ready SHALL pulse for one cycle; the winner's pend clears; the winner's address counter advances by 0x40, wrapping modulo 2^32; the FSM returns to IDLE.
REQ-010 mem_data SHALL hold its value until the next capture.
REQ-011 Minimum latency SHALL be: req at cycle N, rd_accept at cycle N+2, rd_data_valid at cycle N+3 gives ready at cycle N+4.
REQ-012 start SHALL load both counters from their bases only in IDLE with no pend set; otherwise start is ignored.
REQ-013 A req while its own pend is set SHALL be dropped and set req_err; req_err clears only on rst.
REQ-014 At most one read SHALL be outstanding; no new rd_valid until RESP completes.

Reset
REQ-015 rst SHALL force: state IDLE, pend_wt = pend_img = 0, last-grant = image (so weight wins the first tie), both counters 0, rd_addr 0, mem_data all 0, req_err 0.
REQ-016 rst SHALL force these outputs to 0: rd_valid, wt_ready, img_ready, busy.
REQ-017 rst mid-transaction SHALL abandon the outstanding read; later rd_data_valid is ignored because the FSM is in IDLE.

Structure
REQ-018 The state enum typedef, BLK_BYTES = 64 and BLK_WORDS = 8 SHALL live in shared package dnn_pkg.
REQ-019 The two-requester round-robin choice SHALL be sub-module dnn_rr_arb2 (inputs: pend[1:0], last_grant; output: grant one-hot).

Verification
REQ-020 Single request: start with wt_base = 0x1000; wt_req; memory accepts immediately and returns data 1 cycle later -> rd_addr = 0x1000, wt_ready at N+4, mem_data = rd_data, next wt_req reads 0x1040.
REQ-021 Simultaneous wt_req and img_req after reset, img_base = 0x8000 -> weight served first, then image at 0x8000; a repeat of both -> order image then weight.
REQ-022 Backpressure: rd_accept held low 5 cycles -> rd_valid and rd_addr stable for all 5 cycles, exactly one read issued.
REQ-023 Wrap: wt_base = 0xFFFFFFC0, two requests -> addresses 0xFFFFFFC0 then 0x00000000.
REQ-024 wt_req during the weight loader's own WAIT -> req_err = 1, only one wt_ready; img_req in the same cycle is still served afterwards.
REQ-025 rst asserted in WAIT, then rd_data_valid -> no ready pulse, mem_data = 0, busy = 0.
